// File: rtl/spi_frame_tx_if.sv
// Handshake and serial-pin bundle for spi_frame_tx.
// The hash core drives the word side; the transmitter drives the pin side.
interface spi_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              manch;
  logic              sdo;
  logic              en_out;
  logic              sclk;
  logic              frame_done;

  modport master (
    output in_data, in_valid, manch,
    input  in_ready, sdo, en_out, sclk, frame_done
  );

  modport slave (
    input  in_data, in_valid, manch,
    output in_ready, sdo, en_out, sclk, frame_done
  );
endinterface

// File: rtl/spi_frame_tx.sv
// Serialises one DATA_W-bit hash word per frame as NRZ or Manchester.
// Every pin output is a register loaded with the value for the cycle after the edge.
module spi_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int CLK_DIV   = 1,
  parameter int IDLE_GAP  = 1
) (
  input  logic           clk,
  input  logic           rst,
  spi_frame_tx_if.slave  bus
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_CYC = IDLE_GAP * 2 * CLK_DIV;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic              r_manch;
  logic [DIV_W-1:0]  r_div;
  logic              r_half;
  logic [BIT_W-1:0]  r_bitIdx;
  logic [GAP_W-1:0]  r_gap;
  logic              r_inReady;
  logic              r_sdo;
  logic              r_enOut;
  logic              r_sclk;
  logic              r_frameDone;

  logic              w_accept;
  logic              w_last;
  logic [DIV_W-1:0]  w_nDiv;
  logic              w_nHalf;
  logic [BIT_W-1:0]  w_nBitIdx;
  logic              w_nDone;

  // Line level for a given bit position; Manchester inverts the second half.
  function automatic logic f_sdo(input logic [DATA_W-1:0] word,
                                 input logic              isManch,
                                 input logic [BIT_W-1:0]  bitIdx,
                                 input logic              half);
    logic [BIT_W-1:0] sel;
    sel   = (LSB_FIRST != 0) ? bitIdx : (BIT_LAST - bitIdx);
    f_sdo = word[sel] ^ (isManch & half);
  endfunction

  // Position of the cycle that follows the one currently on the pins.
  always_comb begin
    w_accept  = bus.in_valid && r_inReady;
    w_last    = (r_div == DIV_MAX) && r_half && (r_bitIdx == BIT_LAST);
    w_nDiv    = r_div;
    w_nHalf   = r_half;
    w_nBitIdx = r_bitIdx;
    if (r_div == DIV_MAX) begin
      w_nDiv = '0;
      if (r_half) begin
        w_nHalf   = 1'b0;
        w_nBitIdx = r_bitIdx + 1'b1;
      end else begin
        w_nHalf = 1'b1;
      end
    end else begin
      w_nDiv = r_div + 1'b1;
    end
    w_nDone = (w_nDiv == DIV_MAX) && w_nHalf && (w_nBitIdx == BIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_manch     <= 1'b0;
      r_div       <= '0;
      r_half      <= 1'b0;
      r_bitIdx    <= '0;
      r_gap       <= '0;
      r_inReady   <= 1'b1;
      r_sdo       <= 1'b0;
      r_enOut     <= 1'b0;
      r_sclk      <= 1'b0;
      r_frameDone <= 1'b0;
    end else if (w_accept) begin
      // Accept from IDLE or from the final cycle of a back-to-back frame.
      r_state     <= S_SHIFT;
      r_word      <= bus.in_data;
      r_manch     <= bus.manch;
      r_div       <= '0;
      r_half      <= 1'b0;
      r_bitIdx    <= '0;
      r_gap       <= '0;
      r_inReady   <= 1'b0;
      r_sdo       <= f_sdo(bus.in_data, bus.manch, '0, 1'b0);
      r_enOut     <= 1'b1;
      r_sclk      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_inReady   <= 1'b1;
          r_sdo       <= 1'b0;
          r_enOut     <= 1'b0;
          r_sclk      <= 1'b0;
          r_frameDone <= 1'b0;
        end

        S_SHIFT: begin
          if (w_last) begin
            r_div       <= '0;
            r_half      <= 1'b0;
            r_bitIdx    <= '0;
            r_gap       <= '0;
            r_sdo       <= 1'b0;
            r_enOut     <= 1'b0;
            r_sclk      <= 1'b0;
            r_frameDone <= 1'b0;
            if (IDLE_GAP == 0) begin
              r_state   <= S_IDLE;
              r_inReady <= 1'b1;
            end else begin
              r_state   <= S_GAP;
              r_inReady <= 1'b0;
            end
          end else begin
            r_div       <= w_nDiv;
            r_half      <= w_nHalf;
            r_bitIdx    <= w_nBitIdx;
            r_sdo       <= f_sdo(r_word, r_manch, w_nBitIdx, w_nHalf);
            r_enOut     <= 1'b1;
            r_sclk      <= w_nHalf;
            r_frameDone <= w_nDone;
            r_inReady   <= (IDLE_GAP == 0) && w_nDone;
          end
        end

        S_GAP: begin
          r_sdo       <= 1'b0;
          r_enOut     <= 1'b0;
          r_sclk      <= 1'b0;
          r_frameDone <= 1'b0;
          if (r_gap == GAP_MAX) begin
            r_state   <= S_IDLE;
            r_gap     <= '0;
            r_inReady <= 1'b1;
          end else begin
            r_gap     <= r_gap + 1'b1;
            r_inReady <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_inReady   <= 1'b1;
          r_sdo       <= 1'b0;
          r_enOut     <= 1'b0;
          r_sclk      <= 1'b0;
          r_frameDone <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_inReady;
  assign bus.sdo        = r_sdo;
  assign bus.en_out     = r_enOut;
  assign bus.sclk       = r_sclk;
  assign bus.frame_done = r_frameDone;

endmodule
